// File: rtl/attribute_overlay_engine_pkg.sv
// rtl/attribute_overlay_engine_pkg.sv - palette, readout/bar geometry, digit font and BCD helper
package attr_overlay_pkg;

    localparam logic [7:0] COLOR_DIGIT     = 8'd15;
    localparam logic [7:0] COLOR_BAR_FULL  = 8'd14;
    localparam logic [7:0] COLOR_BAR_FILL  = 8'd12;
    localparam logic [7:0] COLOR_BAR_EMPTY = 8'd8;

    localparam int NUM_READOUT   = 5;
    localparam int READOUT_X0    = 37;
    localparam int READOUT_PITCH = 25;
    localparam int READOUT_Y     = 102;
    localparam int CELL_W        = 6;
    localparam int CELL_H        = 8;
    localparam int GLYPH_W       = 5;
    localparam int GLYPH_H       = 7;

    localparam int BAR_X0    = 37;
    localparam int BAR_PITCH = 25;
    localparam int BAR_SEG_W = 16;
    localparam int BAR_Y0    = 136;
    localparam int BAR_H     = 8;

    localparam logic [13:0] VALUE_MAX = 14'd9999;

    // 5x7 glyphs, row 0 in bits [34:30], column 0 is the MSB of each row
    function automatic logic [34:0] font_glyph(input logic [3:0] digit);
        case (digit)
            4'd0:    font_glyph = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
            4'd1:    font_glyph = {5'b11100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b11111};
            4'd2:    font_glyph = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
            4'd3:    font_glyph = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
            4'd4:    font_glyph = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
            4'd5:    font_glyph = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
            4'd6:    font_glyph = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
            4'd7:    font_glyph = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
            4'd8:    font_glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
            4'd9:    font_glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100};
            default: font_glyph = '0;
        endcase
    endfunction

    // Double-dabble; input is already saturated to 9999 so four BCD digits suffice
    function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
        logic [15:0] bcd;
        bcd = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int n = 0; n < 4; n++) begin
                if (bcd[n*4 +: 4] >= 4'd5) begin
                    bcd[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
                end
            end
            bcd = {bcd[14:0], bin[i]};
        end
        return bcd;
    endfunction

endpackage

// File: rtl/attribute_overlay_engine_digit_line_glyph.sv
// rtl/attribute_overlay_engine_digit_line_glyph.sv - one decimal readout line, leading-zero suppressed
module digit_line_glyph
    import attr_overlay_pkg::*;
#(
    parameter int ORIGIN_X  = 37,
    parameter int ORIGIN_Y  = 102,
    parameter int NUM_DIGIT = 4
) (
    input  logic [9:0]  posX,
    input  logic [9:0]  posY,
    input  logic [13:0] Value,
    output logic        lit
);

    logic [9:0]  w_rel_x;
    logic [9:0]  w_rel_y;
    logic [13:0] w_value_sat;
    logic [15:0] w_bcd;
    logic [9:0]  w_digit_idx;
    logic [9:0]  w_col;
    logic        w_in_area;
    logic        w_in_glyph;
    logic [3:0]  w_digit;
    logic        w_shown;
    logic [34:0] w_glyph;
    logic [5:0]  w_bit_idx;

    assign w_rel_x     = posX - 10'(ORIGIN_X);
    assign w_rel_y     = posY - 10'(ORIGIN_Y);
    assign w_value_sat = (Value > VALUE_MAX) ? VALUE_MAX : Value;
    assign w_bcd       = bin2bcd(w_value_sat);
    assign w_digit_idx = w_rel_x / 10'(CELL_W);
    assign w_col       = w_rel_x % 10'(CELL_W);
    assign w_in_area   = (w_rel_x < 10'(CELL_W * NUM_DIGIT)) && (w_rel_y < 10'(CELL_H));
    assign w_in_glyph  = w_in_area && (w_col < 10'(GLYPH_W)) && (w_rel_y < 10'(GLYPH_H));
    assign w_glyph     = font_glyph(w_digit);
    assign w_bit_idx   = 6'd34 - 6'(w_rel_y[2:0]) * 6'd5 - 6'(w_col[2:0]);

    // Select the digit under the pixel; a digit is shown once any more significant digit (or itself) is nonzero
    always_comb begin : p_digit_sel
        logic seen;
        seen    = 1'b0;
        w_digit = 4'd0;
        w_shown = 1'b0;
        for (int d = 0; d < NUM_DIGIT; d++) begin
            seen = seen | (w_bcd[4*(NUM_DIGIT-1-d) +: 4] != 4'd0) | (d == NUM_DIGIT - 1);
            if (w_digit_idx == 10'(d)) begin
                w_digit = w_bcd[4*(NUM_DIGIT-1-d) +: 4];
                w_shown = seen;
            end
        end
    end

    // Glyph lookup, guarded so blank column/row never index the font
    always_comb begin
        lit = 1'b0;
        if (w_in_glyph && w_shown) begin
            lit = w_glyph[w_bit_idx];
        end
    end

endmodule

// File: rtl/attribute_overlay_engine.sv
// rtl/attribute_overlay_engine.sv - attribute panel overlay: tile addressing, readouts, energy bar (option ENERGY_BLINK_EN)
module attribute_overlay_engine
    import attr_overlay_pkg::*;
#(
    parameter int COOR_X     = 32,
    parameter int COOR_Y     = 32,
    parameter int SIZE_X     = 192,
    parameter int SIZE_Y     = 160,
    parameter int TILE_WIDTH = 32,
    parameter int NUM_DIGIT  = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             FRAME_CLK,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic [4:0][13:0] ValueArr,
    input  logic [4:0]       EnergyDone,
    input  logic [3:0]       EnergyProgress,
    output logic [3:0]       tileX,
    output logic [3:0]       tileY,
    output logic [9:0]       relPos,
    output logic             inPanel,
    output logic             isEnergyBar,
    output logic [7:0]       BAR_COLOR_ID,
    output logic             isDigit
);

    localparam int         TW_LOG2 = $clog2(TILE_WIDTH);
    localparam logic [9:0] TW_MASK = 10'(TILE_WIDTH - 1);

    logic [9:0]             w_pos_x;
    logic [9:0]             w_pos_y;
    logic                   w_in_panel;
    logic [NUM_READOUT-1:0] w_lit;
    logic                   w_bar_hit;
    logic [7:0]             w_bar_color;
    logic [7:0]             w_done_color;
    logic [2:0]             r_frame_sync;
    logic [7:0]             r_frame_cnt;

    assign w_pos_x    = DrawX - 10'(COOR_X);
    assign w_pos_y    = DrawY - 10'(COOR_Y);
    assign w_in_panel = (w_pos_x < 10'(SIZE_X)) && (w_pos_y < 10'(SIZE_Y));
    assign tileX      = 4'(w_pos_x >> TW_LOG2);
    assign tileY      = 4'(w_pos_y >> TW_LOG2);
    assign relPos     = ((w_pos_y & TW_MASK) << TW_LOG2) | (w_pos_x & TW_MASK);

    for (genvar gi = 0; gi < NUM_READOUT; gi++) begin : g_readout
        digit_line_glyph #(
            .ORIGIN_X  (READOUT_X0 + READOUT_PITCH * gi),
            .ORIGIN_Y  (READOUT_Y),
            .NUM_DIGIT (NUM_DIGIT)
        ) u_glyph (
            .posX  (w_pos_x),
            .posY  (w_pos_y),
            .Value (ValueArr[gi]),
            .lit   (w_lit[gi])
        );
    end

    // Frame strobe: two-flop synchroniser plus history flop, count rising edges
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_frame_sync <= '0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_sync <= {r_frame_sync[1:0], FRAME_CLK};
            if (r_frame_sync[1] && !r_frame_sync[2]) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

`ifdef ENERGY_BLINK_EN
    assign w_done_color = r_frame_cnt[3] ? COLOR_BAR_EMPTY : COLOR_BAR_FULL;
`else
    assign w_done_color = COLOR_BAR_FULL;
`endif

    // Energy bar: segment hit test, active segment is the lowest one not yet done
    always_comb begin : p_bar
        logic       found_active;
        logic [9:0] seg_col;
        found_active = 1'b0;
        seg_col      = '0;
        w_bar_hit    = 1'b0;
        w_bar_color  = 8'd0;
        for (int i = 0; i < NUM_READOUT; i++) begin
            seg_col = w_pos_x - 10'(BAR_X0 + BAR_PITCH * i);
            if (w_pos_y >= 10'(BAR_Y0) && w_pos_y < 10'(BAR_Y0 + BAR_H)
                && seg_col < 10'(BAR_SEG_W)) begin
                w_bar_hit = 1'b1;
                if (EnergyDone[i]) begin
                    w_bar_color = w_done_color;
                end else if (!found_active && seg_col[3:0] < EnergyProgress) begin
                    w_bar_color = COLOR_BAR_FILL;
                end else begin
                    w_bar_color = COLOR_BAR_EMPTY;
                end
            end
            if (!EnergyDone[i]) begin
                found_active = 1'b1;
            end
        end
    end

    // Output stage aligned with the tile ROM; everything forced low outside the panel
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            inPanel      <= 1'b0;
            isEnergyBar  <= 1'b0;
            BAR_COLOR_ID <= 8'd0;
            isDigit      <= 1'b0;
        end else begin
            inPanel      <= w_in_panel;
            isEnergyBar  <= w_in_panel && w_bar_hit;
            BAR_COLOR_ID <= (w_in_panel && w_bar_hit) ? w_bar_color : 8'd0;
            isDigit      <= w_in_panel && (|w_lit);
        end
    end

endmodule

// File: tb/tb_attribute_overlay_engine.sv
// tb/tb_attribute_overlay_engine.sv - scoreboard bench for attribute_overlay_engine
module tb_attribute_overlay_engine;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             FRAME_CLK = 1'b0;
    logic [9:0]       DrawX = 10'd40;
    logic [9:0]       DrawY = 10'd140;
    logic [4:0][13:0] ValueArr;
    logic [4:0]       EnergyDone = 5'b00001;
    logic [3:0]       EnergyProgress = 4'd4;
    logic [3:0]       tileX;
    logic [3:0]       tileY;
    logic [9:0]       relPos;
    logic             inPanel;
    logic             isEnergyBar;
    logic [7:0]       BAR_COLOR_ID;
    logic             isDigit;

    typedef struct packed {
        logic       in_panel;
        logic       bar;
        logic [7:0] color;
        logic       digit;
    } resp_t;

    resp_t exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;
    logic  tb_issue = 1'b0;
    logic  r_vld = 1'b0;

    attribute_overlay_engine dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .FRAME_CLK      (FRAME_CLK),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .ValueArr       (ValueArr),
        .EnergyDone     (EnergyDone),
        .EnergyProgress (EnergyProgress),
        .tileX          (tileX),
        .tileY          (tileY),
        .relPos         (relPos),
        .inPanel        (inPanel),
        .isEnergyBar    (isEnergyBar),
        .BAR_COLOR_ID   (BAR_COLOR_ID),
        .isDigit        (isDigit)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) r_vld <= tb_issue;

    always @(negedge CLK) begin
        if (r_vld) begin
            resp_t act;
            resp_t exp;
            string nm;
            act = '{inPanel, isEnergyBar, BAR_COLOR_ID, isDigit};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_underflow: output presented with no expectation queued");
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (act !== exp) begin
                    fails++;
                    $display("FAIL %s: got inPanel=%b bar=%b color=%0d digit=%b, expected inPanel=%b bar=%b color=%0d digit=%b",
                             nm, act.in_panel, act.bar, act.color, act.digit,
                             exp.in_panel, exp.bar, exp.color, exp.digit);
                end
            end
        end
    end

    task automatic issue(input int x, input int y, input logic [4:0] done, input logic [3:0] prog,
                         input logic e_in, input logic e_bar, input logic [7:0] e_col,
                         input logic e_dig, input string nm);
        @(negedge CLK);
        DrawX          = 10'(x);
        DrawY          = 10'(y);
        EnergyDone     = done;
        EnergyProgress = prog;
        exp_q.push_back('{e_in, e_bar, e_col, e_dig});
        name_q.push_back(nm);
        tb_issue       = 1'b1;
    endtask

    task automatic idle(input int cycles);
        @(negedge CLK);
        tb_issue = 1'b0;
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic check_comb(input logic [3:0] etx, input logic [3:0] ety, input logic [9:0] erel, input string nm);
        #1;
        tests++;
        if (tileX !== etx || tileY !== ety || relPos !== erel) begin
            fails++;
            $display("FAIL %s: got tileX=%0d tileY=%0d relPos=%0d, expected tileX=%0d tileY=%0d relPos=%0d",
                     nm, tileX, tileY, relPos, etx, ety, erel);
        end
    endtask

    task automatic check_reset(input string nm);
        tests++;
        if (inPanel !== 1'b0 || isEnergyBar !== 1'b0 || BAR_COLOR_ID !== 8'd0 || isDigit !== 1'b0) begin
            fails++;
            $display("FAIL %s: got inPanel=%b bar=%b color=%0d digit=%b, expected all zero",
                     nm, inPanel, isEnergyBar, BAR_COLOR_ID, isDigit);
        end
    endtask

`ifdef ENERGY_BLINK_EN
    task automatic frame_edges(input int n);
        for (int k = 0; k < n; k++) begin
            FRAME_CLK = 1'b1;
            repeat (4) @(negedge CLK);
            FRAME_CLK = 1'b0;
            repeat (4) @(negedge CLK);
        end
    endtask
`endif

    initial begin
        ValueArr[0] = 14'd1234;
        ValueArr[1] = 14'd7;
        ValueArr[2] = 14'd16383;
        ValueArr[3] = 14'd0;
        ValueArr[4] = 14'd50;

        repeat (3) @(negedge CLK);
        check_reset("reset_outputs_zero");

        @(negedge CLK);
        RESET_N = 1'b1;
        exp_q.push_back('{1'b1, 1'b0, 8'd0, 1'b0});
        name_q.push_back("reset_release_inpanel");
        tb_issue = 1'b1;

        // position / tiling
        issue(100, 75, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "pos_in_panel");
        check_comb(4'd2, 4'd1, 10'd356, "tile_100_75");
        issue(10, 75, 5'b00001, 4'd4, 0, 0, 8'd0, 0, "pos_left_wrap");
        check_comb(4'd15, 4'd1, 10'd362, "tile_left_wrap");
        issue(100, 10, 5'b00001, 4'd4, 0, 0, 8'd0, 0, "pos_above");
        issue(223, 32, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "edge_x191_y0");
        issue(224, 32, 5'b00001, 4'd4, 0, 0, 8'd0, 0, "edge_x192");
        issue(100, 191, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "edge_y159");
        issue(100, 192, 5'b00001, 4'd4, 0, 0, 8'd0, 0, "edge_y160");

        // readouts
        issue(69, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 1, "dig0_one_top");
        issue(74, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "dig0_blank_col");
        issue(75, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "dig0_two_col0");
        issue(76, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 1, "dig0_two_col1");
        issue(95, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "dig1_lead_zero");
        issue(112, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 1, "dig1_seven");
        issue(120, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 1, "dig2_sat_d0");
        issue(119, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "dig2_sat_d0_col0");
        issue(123, 137, 5'b00001, 4'd4, 1, 0, 8'd0, 1, "dig2_sat_row3");
        issue(138, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 1, "dig2_sat_d3");
        issue(120, 141, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "dig2_blank_row7");
        issue(163, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 1, "dig3_zero_lsd");
        issue(145, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "dig3_zero_d0");
        issue(181, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 1, "dig4_fifty_five");
        issue(176, 134, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "dig4_fifty_lead");

        // energy bar
        issue(69, 168, 5'b00001, 4'd4, 1, 1, 8'd14, 0, "bar_seg0_first");
        issue(84, 175, 5'b00001, 4'd4, 1, 1, 8'd14, 0, "bar_seg0_last");
        issue(85, 168, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "bar_gap_after0");
        issue(68, 168, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "bar_before0");
        issue(69, 167, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "bar_row135");
        issue(69, 176, 5'b00001, 4'd4, 1, 0, 8'd0, 0, "bar_row144");
        issue(94, 172, 5'b00001, 4'd4, 1, 1, 8'd12, 0, "bar_seg1_c0");
        issue(97, 172, 5'b00001, 4'd4, 1, 1, 8'd12, 0, "bar_seg1_c3");
        issue(98, 172, 5'b00001, 4'd4, 1, 1, 8'd8, 0, "bar_seg1_c4");
        issue(109, 172, 5'b00001, 4'd4, 1, 1, 8'd8, 0, "bar_seg1_c15");
        issue(169, 168, 5'b00001, 4'd4, 1, 1, 8'd8, 0, "bar_seg4_first");
        issue(184, 175, 5'b00001, 4'd4, 1, 1, 8'd8, 0, "bar_seg4_last");
        issue(69, 168, 5'b00000, 4'd0, 1, 1, 8'd8, 0, "bar_none_prog0");
        issue(83, 168, 5'b00000, 4'd15, 1, 1, 8'd12, 0, "bar_none_prog15_c14");
        issue(84, 168, 5'b00000, 4'd15, 1, 1, 8'd8, 0, "bar_none_prog15_c15");
        issue(69, 168, 5'b00101, 4'd3, 1, 1, 8'd14, 0, "bar_multi_seg0");
        issue(96, 168, 5'b00101, 4'd3, 1, 1, 8'd12, 0, "bar_multi_seg1");
        issue(119, 168, 5'b00101, 4'd3, 1, 1, 8'd14, 0, "bar_multi_seg2");
        issue(144, 168, 5'b00101, 4'd3, 1, 1, 8'd8, 0, "bar_multi_seg3");

`ifdef ENERGY_BLINK_EN
        issue(72, 168, 5'b00001, 4'd4, 1, 1, 8'd14, 0, "blink_frame0");
        idle(1);
        frame_edges(8);
        issue(72, 168, 5'b00001, 4'd4, 1, 1, 8'd8, 0, "blink_frame8");
        idle(1);
        frame_edges(8);
        issue(72, 168, 5'b00001, 4'd4, 1, 1, 8'd14, 0, "blink_frame16");
`endif

        idle(3);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
